// File: rtl/seven_segment_scan_decoder.sv
// Rebuilds four BCD digits from the multiplexed
// active-low anode/segment lines of a 4-digit display.
module seven_segment_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        i_Clk,
  input  logic        i_Rst_L,
  input  logic [3:0]  i_Anodes,
  input  logic [6:0]  i_Segments,
  input  logic        i_Err_Clr,
  output logic [15:0] o_BCD,
  output logic        o_Valid,
  output logic        o_Frame_Done,
  output logic [3:0]  o_Error
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);
  localparam logic [10:0] IDLE_SAMPLE = {4'hF, 7'h00};

  logic [10:0] r_Sample;
  logic [7:0]  r_Count;
  logic [3:0]  r_Seen;

  logic [10:0] w_Sample;
  logic        w_Qual;
  logic [1:0]  w_Digit;
  logic        w_Match;
  logic        w_Capture;
  logic [7:0]  w_Count_Nxt;
  logic [3:0]  w_Nibble;
  logic        w_Bad;
  logic [3:0]  w_Onehot;
  logic [3:0]  w_Seen_Or;
  logic        w_Full;

  assign w_Sample = {i_Anodes, i_Segments};

  // Map a single low anode to its digit index
  always_comb begin
    w_Qual  = 1'b1;
    w_Digit = 2'd0;
    unique case (i_Anodes)
      4'b1110: w_Digit = 2'd0;
      4'b1101: w_Digit = 2'd1;
      4'b1011: w_Digit = 2'd2;
      4'b0111: w_Digit = 2'd3;
      default: w_Qual  = 1'b0;
    endcase
  end

  assign w_Match   = w_Qual && (w_Sample == r_Sample);
  assign w_Capture = w_Match && (r_Count == STABLE - 8'd1);
  assign w_Onehot  = 4'(1) << w_Digit;
  assign w_Seen_Or = r_Seen | w_Onehot;
  assign w_Full    = &w_Seen_Or;

  // Saturating stability count, cleared on any change
  always_comb begin
    w_Count_Nxt = 8'd0;
    if (w_Match) begin
      if (r_Count == STABLE) w_Count_Nxt = STABLE;
      else                   w_Count_Nxt = r_Count + 8'd1;
    end
  end

  // Segment pattern to digit code ({g,f,e,d,c,b,a}, 0 = lit)
  always_comb begin
    w_Nibble = 4'hB;
    w_Bad    = 1'b0;
    unique case (i_Segments)
      7'h40:   w_Nibble = 4'd0;
      7'h79:   w_Nibble = 4'd1;
      7'h24:   w_Nibble = 4'd2;
      7'h30:   w_Nibble = 4'd3;
      7'h19:   w_Nibble = 4'd4;
      7'h12:   w_Nibble = 4'd5;
      7'h02:   w_Nibble = 4'd6;
      7'h78:   w_Nibble = 4'd7;
      7'h00:   w_Nibble = 4'd8;
      7'h10:   w_Nibble = 4'd9;
      7'h3F:   w_Nibble = 4'hF;
      7'h7F:   w_Nibble = 4'hA;
      default: w_Bad    = 1'b1;
    endcase
  end

  // Input sample and stability counter
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Sample <= IDLE_SAMPLE;
      r_Count  <= 8'd0;
    end else begin
      r_Sample <= w_Sample;
      r_Count  <= w_Count_Nxt;
    end
  end

  // Digit capture, frame tracking and sticky error flags
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_BCD        <= 16'hAAAA;
      o_Valid      <= 1'b0;
      o_Frame_Done <= 1'b0;
      o_Error      <= 4'b0000;
      r_Seen       <= 4'b0000;
    end else begin
      o_Frame_Done <= w_Capture && w_Full;
      o_Error <= (i_Err_Clr ? 4'b0000 : o_Error)
               | ((w_Capture && w_Bad) ? w_Onehot : 4'b0000);
      if (w_Capture) begin
        o_BCD[{w_Digit, 2'b00} +: 4] <= w_Nibble;
        if (w_Full) begin
          o_Valid <= 1'b1;
          r_Seen  <= 4'b0000;
        end else begin
          r_Seen  <= w_Seen_Or;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Directed and random checks of the display scan
// decoder against a run-length reference model.
module tb_seven_segment_scan_decoder;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        clr;
  logic [15:0] o_BCD;
  logic        o_Valid;
  logic        o_Frame_Done;
  logic [3:0]  o_Error;

  always #5 clk = ~clk;

  seven_segment_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_n),
    .i_Anodes     (an),
    .i_Segments   (seg),
    .i_Err_Clr    (clr),
    .o_BCD        (o_BCD),
    .o_Valid      (o_Valid),
    .o_Frame_Done (o_Frame_Done),
    .o_Error      (o_Error)
  );

  int checks = 0;
  int failures = 0;
  int fd_cnt = 0;

  // Reference state
  logic [15:0] m_bcd;
  logic        m_valid;
  logic        m_fd;
  logic [3:0]  m_err;
  logic [3:0]  m_mask;
  logic [10:0] m_prev;
  int          m_hold;

  // Patterns written as abcdefg, leftmost char is segment a
  logic [6:0] abc_tab [12] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b1111110, 7'b1111111
  };

  function automatic logic [6:0] to_bus(input logic [6:0] abc);
    logic [6:0] r;
    for (int i = 0; i < 7; i++) r[i] = abc[6-i];
    return r;
  endfunction

  function automatic logic [6:0] pat(input int idx);
    return to_bus(abc_tab[idx]);
  endfunction

  // Returns {bad, code}
  function automatic logic [4:0] ref_dec(input logic [6:0] s);
    for (int i = 0; i < 12; i++) begin
      if (pat(i) == s) begin
        if (i < 10)  return {1'b0, 4'(i)};
        if (i == 10) return {1'b0, 4'hF};
        return {1'b0, 4'hA};
      end
    end
    return {1'b1, 4'hB};
  endfunction

  function automatic logic [3:0] dig(input int k);
    return ~(4'b0001 << k);
  endfunction

  task automatic model_reset();
    m_bcd   = 16'hAAAA;
    m_valid = 1'b0;
    m_fd    = 1'b0;
    m_err   = 4'b0000;
    m_mask  = 4'b0000;
    m_prev  = {4'hF, 7'h00};
    m_hold  = 0;
  endtask

  task automatic model_edge(input logic [3:0] a,
                            input logic [6:0] s,
                            input logic c);
    logic [4:0] d;
    int k;
    int lows;
    m_fd = 1'b0;
    if ({a, s} == m_prev) begin
      if (m_hold < 1000) m_hold++;
    end else begin
      m_hold = 1;
    end
    m_prev = {a, s};
    if (c) m_err = 4'b0000;
    lows = 0;
    k = 0;
    for (int i = 0; i < 4; i++)
      if (!a[i]) begin lows++; k = i; end
    if (lows == 1 && m_hold == S + 1) begin
      d = ref_dec(s);
      m_bcd[4*k +: 4] = d[3:0];
      if (d[4]) m_err[k] = 1'b1;
      m_mask[k] = 1'b1;
      if (m_mask == 4'hF) begin
        m_fd = 1'b1;
        m_valid = 1'b1;
        m_mask = 4'h0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    checks++;
    assert (o_BCD === m_bcd) else begin
      failures++;
      $error("FAIL %s bcd got %h want %h", tag, o_BCD, m_bcd);
    end
    checks++;
    assert (o_Valid === m_valid) else begin
      failures++;
      $error("FAIL %s valid got %b want %b", tag, o_Valid, m_valid);
    end
    checks++;
    assert (o_Frame_Done === m_fd) else begin
      failures++;
      $error("FAIL %s frame_done got %b want %b",
             tag, o_Frame_Done, m_fd);
    end
    checks++;
    assert (o_Error === m_err) else begin
      failures++;
      $error("FAIL %s error got %b want %b", tag, o_Error, m_err);
    end
  endtask

  task automatic check16(input string tag,
                         input logic [15:0] got,
                         input logic [15:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  // Called at a negedge; drives, clocks, then checks at next negedge
  task automatic cyc(input logic [3:0] a,
                     input logic [6:0] s,
                     input logic c,
                     input string tag);
    an  = a;
    seg = s;
    clr = c;
    @(posedge clk);
    if (rst_n) model_edge(a, s, c);
    @(negedge clk);
    check_all(tag);
    if (o_Frame_Done === 1'b1) fd_cnt++;
  endtask

  task automatic hold(input logic [3:0] a,
                      input logic [6:0] s,
                      input int n,
                      input string tag);
    for (int i = 0; i < n; i++) cyc(a, s, 1'b0, tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    an  = 4'hF;
    seg = 7'h7F;
    clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    check_all("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    logic [6:0] bad_pat;
    logic [3:0] ra;
    logic [6:0] rs;
    int n;
    bad_pat = to_bus(7'b1110000);
    model_reset();
    do_reset();

    // Full frame 1,2,3,4
    fd_cnt = 0;
    for (int k = 0; k < 4; k++) hold(dig(k), pat(k + 1), 10, "scan");
    check16("frame_bcd", o_BCD, 16'h4321);
    check16("frame_valid", {15'd0, o_Valid}, 16'd1);
    check16("frame_err", {12'd0, o_Error}, 16'd0);
    check16("frame_pulses", 16'(fd_cnt), 16'd1);

    // Hold too short, then just long enough
    do_reset();
    hold(dig(2), pat(3), 4, "short");
    cyc(4'hF, pat(3), 1'b0, "short_gap");
    check16("short_nocap", o_BCD, 16'hAAAA);
    hold(dig(2), pat(3), 4, "edge4");
    check16("edge4_nocap", o_BCD, 16'hAAAA);
    cyc(dig(2), pat(3), 1'b0, "edge5");
    check16("edge5_cap", o_BCD, 16'hA3AA);

    // Two anodes low never qualifies
    hold(4'b1100, pat(8), 20, "multi");
    check16("multi_bcd", o_BCD, 16'hA3AA);
    check16("multi_cnt", {8'd0, dut.r_Count}, 16'd0);

    // Unknown pattern, clear racing a new error
    hold(dig(1), bad_pat, 10, "bad");
    check16("bad_err", {12'd0, o_Error}, 16'h0002);
    check16("bad_bcd", o_BCD, 16'hA3BA);
    cyc(4'hF, 7'h7F, 1'b0, "bad_gap");
    hold(dig(1), bad_pat, 4, "bad2");
    cyc(dig(1), bad_pat, 1'b1, "set_wins");
    check16("set_wins_err", {12'd0, o_Error}, 16'h0002);
    hold(4'hF, 7'h7F, 2, "idle");
    cyc(4'hF, 7'h7F, 1'b1, "clr");
    check16("clr_err", {12'd0, o_Error}, 16'h0000);

    // Dash and blank
    hold(dig(0), pat(10), 10, "dash");
    hold(dig(3), pat(9), 10, "nine");
    hold(dig(3), pat(11), 10, "blank");
    check16("dash_nib", {12'd0, o_BCD[3:0]}, 16'h000F);
    check16("blank_nib", {12'd0, o_BCD[15:12]}, 16'h000A);

    // Random scanning with glitches and clears
    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(7) == 0) ra = 4'($urandom_range(15));
      else ra = dig($urandom_range(3));
      if ($urandom_range(7) == 0) rs = 7'($urandom_range(127));
      else rs = pat($urandom_range(11));
      n = $urandom_range(1, 8);
      for (int j = 0; j < n; j++)
        cyc(ra, rs, 1'($urandom_range(7) == 0), "rand");
    end

    // Asynchronous reset mid-frame
    do_reset();
    hold(dig(0), pat(5), 10, "pre0");
    hold(dig(1), pat(6), 10, "pre1");
    check16("pre_bcd", o_BCD, 16'hAA65);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    check16("async_bcd", o_BCD, 16'hAAAA);
    @(negedge clk);
    rst_n = 1'b1;
    fd_cnt = 0;
    hold(dig(2), pat(7), 10, "post2");
    hold(dig(3), pat(9), 10, "post3");
    check16("post_bcd", o_BCD, 16'h97AA);
    check16("post_nofd", 16'(fd_cnt), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
